ct_f_spsram_param_init: RTL and testbench

//  Parametrised single-port FPGA SRAM wrapper: depth 2^ADDR_WIDTH, any DATA_WIDTH.

---
 rtl/ct_f_spsram_param_init.sv | 126 ++++++++++++
 tb/tb_ct_f_spsram_param_init.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_param_init.sv
// Parametrised single-port SRAM wrapper: per-slice write enables, zero-fill clear
// engine (after reset and on request) and an optional output pipeline register.
module ct_f_spsram_param_init #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 196,
  parameter int WRAP_SIZE  = 48,
  parameter int OUT_REG    = 0,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  INIT_REQ,
  output logic                  INIT_BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NS    = (DATA_WIDTH + WRAP_SIZE - 1) / WRAP_SIZE;

  typedef enum logic {IDLE, INIT} state_t;

  state_t                  state_reg;
  logic                    busy_reg;
  logic [ADDR_WIDTH-1:0]   init_cnt_reg;
  logic [ADDR_WIDTH-1:0]   addr_holding_reg;
  logic                    rd_pending_reg;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_q;
  logic                    unused_bits;

  // Only the MSB of each slice's WEN field matters; rd_pending is idle when OUT_REG=0.
  assign unused_bits = ^{WEN, rd_pending_reg};

  assign INIT_BUSY = busy_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg        <= (INIT_EN != 0) ? INIT : IDLE;
      busy_reg         <= (INIT_EN != 0);
      init_cnt_reg     <= '0;
      addr_holding_reg <= '0;
      rd_pending_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!CEN) begin
            addr_holding_reg <= A;
          end
          rd_pending_reg <= !CEN && GWEN;
          if (INIT_REQ) begin
            state_reg <= INIT;
            busy_reg  <= 1'b1;
          end
        end
        INIT: begin
          rd_pending_reg <= 1'b0;
          // Counter wraps to zero on its own after the last entry.
          init_cnt_reg   <= init_cnt_reg + 1'b1;
          if (&init_cnt_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ram_addr = A;
    if (busy_reg) begin
      ram_addr = init_cnt_reg;
    end else if (CEN) begin
      ram_addr = addr_holding_reg;
    end
  end

  for (genvar gi = 0; gi < NS; gi++) begin : g_slice
    localparam int LO = gi * WRAP_SIZE;
    localparam int HI = ((gi + 1) * WRAP_SIZE > DATA_WIDTH) ? DATA_WIDTH - 1
                                                            : (gi + 1) * WRAP_SIZE - 1;
    localparam int W  = HI - LO + 1;

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_reg;
    logic         we;
    logic [W-1:0] wdata;

    assign we    = busy_reg || (!CEN && !GWEN && !WEN[HI]);
    assign wdata = busy_reg ? '0 : D[HI:LO];

    always_ff @(posedge CLK) begin
      if (we) begin
        mem[ram_addr] <= wdata;
      end
      rd_reg <= mem[ram_addr];
    end

    assign ram_q[HI:LO] = rd_reg;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q_reg;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        q_reg <= '0;
      end else if (rd_pending_reg) begin
        q_reg <= ram_q;
      end
    end

    assign Q = q_reg;
  end else begin : g_no_out_reg
    assign Q = ram_q;
  end

endmodule

// File: tb/tb_ct_f_spsram_param_init.sv
// Scoreboard bench: a 196-bit fill-enabled instance (latency 1) and a 100-bit
// no-fill instance with the output register (latency 2).
module tb_ct_f_spsram_param_init;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]   a0;
  logic         cen0, gwen0, ireq0, busy0;
  logic [195:0] d0, wen0, q0;

  logic [7:0]   a1;
  logic         cen1, gwen1, ireq1, busy1;
  logic [99:0]  d1, wen1, q1;

  ct_f_spsram_param_init #(
    .ADDR_WIDTH(8), .DATA_WIDTH(196), .WRAP_SIZE(48), .OUT_REG(0), .INIT_EN(1)
  ) dut0 (
    .CLK(clk), .RST(rst), .A(a0), .CEN(cen0), .D(d0), .GWEN(gwen0), .WEN(wen0),
    .Q(q0), .INIT_REQ(ireq0), .INIT_BUSY(busy0)
  );

  ct_f_spsram_param_init #(
    .ADDR_WIDTH(8), .DATA_WIDTH(100), .WRAP_SIZE(48), .OUT_REG(1), .INIT_EN(0)
  ) dut1 (
    .CLK(clk), .RST(rst), .A(a1), .CEN(cen1), .D(d1), .GWEN(gwen1), .WEN(wen1),
    .Q(q1), .INIT_REQ(ireq1), .INIT_BUSY(busy1)
  );

  int checks = 0;
  int errors = 0;

  logic [195:0] exp0_q[$];
  logic [99:0]  exp1_q[$];
  logic         iss0 = 1'b0;
  logic         iss1 = 1'b0;
  logic [1:0]   pipe0 = '0;
  logic [1:0]   pipe1 = '0;

  task automatic check(input string nm, input logic [195:0] act, input logic [195:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Expected-response timing: dut0 answers one cycle after issue, dut1 two.
  always @(posedge clk) begin
    pipe0 <= {pipe0[0], iss0};
    pipe1 <= {pipe1[0], iss1};
  end

  always @(negedge clk) begin
    logic [195:0] e0;
    logic [99:0]  e1;
    if (pipe0[0]) begin
      if (exp0_q.size() == 0) begin
        check("q0_queue_underflow", 196'd0, 196'd1);
      end else begin
        e0 = exp0_q.pop_front();
        $display("dut0 q=%h", q0);
        check("q0_read", q0, e0);
      end
    end
    if (pipe1[1]) begin
      if (exp1_q.size() == 0) begin
        check("q1_queue_underflow", 196'd0, 196'd1);
      end else begin
        e1 = exp1_q.pop_front();
        $display("dut1 q=%h", q1);
        check("q1_read", {96'd0, q1}, {96'd0, e1});
      end
    end
  end

  task automatic cyc0(input logic cen, input logic gwen, input logic [7:0] a,
                      input logic [195:0] d, input logic [195:0] wen, input logic ireq,
                      input logic expv, input logic [195:0] expd);
    cen0 = cen; gwen0 = gwen; a0 = a; d0 = d; wen0 = wen; ireq0 = ireq; iss0 = expv;
    if (expv) exp0_q.push_back(expd);
    @(negedge clk);
    iss0 = 1'b0; ireq0 = 1'b0; cen0 = 1'b1; gwen0 = 1'b1;
  endtask

  task automatic cyc1(input logic cen, input logic gwen, input logic [7:0] a,
                      input logic [99:0] d, input logic [99:0] wen,
                      input logic expv, input logic [99:0] expd);
    cen1 = cen; gwen1 = gwen; a1 = a; d1 = d; wen1 = wen; iss1 = expv;
    if (expv) exp1_q.push_back(expd);
    @(negedge clk);
    iss1 = 1'b0; cen1 = 1'b1; gwen1 = 1'b1;
  endtask

  task automatic wr0(input logic [7:0] a, input logic [195:0] d, input logic [195:0] wen);
    cyc0(1'b0, 1'b0, a, d, wen, 1'b0, 1'b0, '0);
  endtask

  task automatic rd0(input logic [7:0] a, input logic [195:0] e);
    cyc0(1'b0, 1'b1, a, '0, '1, 1'b0, 1'b1, e);
  endtask

  task automatic wr1(input logic [7:0] a, input logic [99:0] d, input logic [99:0] wen);
    cyc1(1'b0, 1'b0, a, d, wen, 1'b0, '0);
  endtask

  task automatic rd1(input logic [7:0] a, input logic [99:0] e);
    cyc1(1'b0, 1'b1, a, '0, '1, 1'b1, e);
  endtask

  // Counts negedges with INIT_BUSY high, starting from the current one.
  task automatic count_busy(output int n, input int drop_at, input int req_at);
    n = 0;
    while (busy0 && n < 1000) begin
      ireq0 = (n == req_at);
      if (n == drop_at) begin
        cen0 = 1'b0; gwen0 = 1'b0; a0 = 8'h00; d0 = '1; wen0 = '0;
      end else begin
        cen0 = 1'b1; gwen0 = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    cen0 = 1'b1; gwen0 = 1'b1; ireq0 = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [195:0] w, e, pat;
    logic [99:0]  w1, e1, full1;
    int n;

    rst = 1'b1;
    cen0 = 1'b1; gwen0 = 1'b1; a0 = '0; d0 = '0; wen0 = '1; ireq0 = 1'b0;
    cen1 = 1'b1; gwen1 = 1'b1; a1 = '0; d1 = '0; wen1 = '1; ireq1 = 1'b0;
    repeat (3) @(negedge clk);
    check("busy0_in_reset", {195'd0, busy0}, 196'd1);
    check("busy1_in_reset", {195'd0, busy1}, 196'd0);
    check("q1_reset", {96'd0, q1}, 196'd0);

    // Power-on fill length.
    rst = 1'b0;
    count_busy(n, -1, -1);
    check("fill_after_reset_cycles", 196'(n), 196'd256);
    rd0(8'h00, '0);
    rd0(8'h7F, '0);
    rd0(8'hFF, '0);

    // Single-slice write through WEN[191:144].
    w = '1; w[191:144] = '0;
    e = '0; e[191:144] = '1;
    wr0(8'h10, '1, w);
    rd0(8'h10, e);
    // GWEN low with all WEN high writes nothing.
    wr0(8'h10, '1, '1);
    rd0(8'h10, e);
    // Non-MSB WEN bits are ignored; MSB of the 4-bit top slice alone writes it.
    w = '1; w[46:0] = '0; w[195] = 1'b0;
    wr0(8'h11, '1, w);
    e = '0; e[195:192] = '1;
    rd0(8'h11, e);

    // Q stable while CEN held high.
    e = '0; e[191:144] = '1;
    rd0(8'h10, e);
    repeat (5) cyc0(1'b1, 1'b1, 8'h55, '0, '1, 1'b0, 1'b1, e);

    // INIT_REQ alongside a write; mid-fill write dropped, mid-fill INIT_REQ ignored.
    pat = {4'hA, {24{8'hA5}}};
    cyc0(1'b0, 1'b0, 8'h20, pat, '0, 1'b1, 1'b0, '0);
    count_busy(n, 200, 50);
    check("fill_on_request_cycles", 196'(n), 196'd256);
    rd0(8'h20, '0);
    rd0(8'h00, '0);
    rd0(8'h10, '0);

    // 100-bit instance: no fill, registered Q, slices 48/48/4.
    full1 = '1;
    wr1(8'h05, '0, '0);
    wr1(8'h06, '0, '0);
    rd1(8'h05, '0);
    w1 = '1; w1[95] = 1'b0;
    wr1(8'h05, '1, w1);
    e1 = '0; e1[95:48] = '1;
    rd1(8'h05, e1);
    w1 = '1; w1[99] = 1'b0;
    wr1(8'h05, full1, w1);
    e1[99:96] = '1;
    rd1(8'h05, e1);
    w1 = '1; w1[47] = 1'b0;
    wr1(8'h05, {52'd0, 48'h123456789ABC}, w1);
    e1[47:0] = 48'h123456789ABC;
    rd1(8'h05, e1);
    rd1(8'h06, '0);
    rd1(8'h05, e1);
    // Registered Q holds across a write and idle cycles.
    cyc1(1'b0, 1'b0, 8'h06, '1, '0, 1'b1, e1);
    repeat (3) cyc1(1'b1, 1'b1, 8'h00, '0, '1, 1'b1, e1);
    rd1(8'h06, '1);
    rd1(8'h05, e1);

    // Reset at fill cycle 100 restarts the full fill.
    cyc0(1'b1, 1'b1, 8'h00, '0, '1, 1'b1, 1'b0, '0);
    repeat (100) @(negedge clk);
    check("busy0_mid_fill", {195'd0, busy0}, 196'd1);
    rst = 1'b1;
    @(negedge clk);
    check("busy0_during_reset", {195'd0, busy0}, 196'd1);
    check("q1_after_reset", {96'd0, q1}, 196'd0);
    rst = 1'b0;
    count_busy(n, -1, -1);
    check("fill_after_midfill_reset_cycles", 196'(n), 196'd256);
    rd0(8'h11, '0);
    rd1(8'h05, e1);

    repeat (4) @(negedge clk);
    check("queues_drained", 196'(exp0_q.size() + exp1_q.size()), 196'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
